// File: rtl/fpu_mant_addsub_pipe.sv
// Pipelined unsigned mantissa add/subtract for the FPU datapath.
// The carry chain is cut into STAGES segments, and each segment has a valid/ready slot with backpressure.
module fpu_mant_addsub_pipe #(
  parameter int WIDTH  = 27,
  parameter int STAGES = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int SEG = (WIDTH + STAGES - 1) / STAGES;

  function automatic logic [WIDTH-1:0] seg_mask(input int lo, input int hi);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i >= lo) && (i < hi);
    end
    return m;
  endfunction

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] vin;

  // A stage may load if it is empty or its successor is moving, so bubbles collapse.
  always_comb begin
    logic nxt;
    nxt = out_ready;
    en  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = !v_q[k] || nxt;
      nxt   = en[k];
    end
  end

  always_comb begin
    vin    = v_q << 1;
    vin[0] = in_valid;
    v_d    = flush ? '0 : ((en & vin) | (~en & v_q));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO_RAW = k * SEG;
    localparam int LO     = (LO_RAW > WIDTH) ? WIDTH : LO_RAW;
    localparam int HI     = (LO + SEG > WIDTH) ? WIDTH : LO + SEG;
    localparam logic [WIDTH-1:0] MASK = seg_mask(LO, HI);

    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] s_in;
    logic [WIDTH-1:0] s_d;
    logic [WIDTH-1:0] s_q;
    logic             c_in;
    logic             c_d;
    logic             c_q;
    logic             ld;
    logic [WIDTH:0]   sum;

    if (k == 0) begin : g_head
      assign a_in = a;
      assign b_in = sub ? ~b : b;
      assign s_in = '0;
      assign c_in = sub;
    end else begin : g_tail
      assign a_in = g_stage[k-1].g_fwd.a_q;
      assign b_in = g_stage[k-1].g_fwd.b_q;
      assign s_in = g_stage[k-1].s_q;
      assign c_in = g_stage[k-1].c_q;
    end

    assign ld = en[k] && vin[k];

    // Operands are masked to this segment, so the carry out can only land on bit HI.
    // All other bits outside the mask stay zero.
    assign sum = {1'b0, a_in & MASK} + {1'b0, b_in & MASK} + ((WIDTH + 1)'(c_in) << LO);

    always_comb begin
      s_d = s_q;
      c_d = c_q;
      if (ld) begin
        s_d = (s_in & ~MASK) | (sum[WIDTH-1:0] & MASK);
        c_d = |(sum & ~{1'b0, MASK});
      end
    end

    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
        s_q <= '0;
        c_q <= '0;
      end else begin
        s_q <= s_d;
        c_q <= c_d;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] a_d;
      logic [WIDTH-1:0] b_d;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (ld) begin
          a_d = a_in;
          b_d = b_in;
        end
      end

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          a_q <= '0;
          b_q <= '0;
        end else begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[STAGES-1];
  assign result    = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_fpu_mant_addsub_pipe.sv
// Bench for fpu_mant_addsub_pipe (WIDTH=27, STAGES=3).
// Directed arithmetic, backpressure, flush and reset cases, then a randomized run checked against a queue scoreboard.
module tb_fpu_mant_addsub_pipe;
  localparam int W = 27;
  localparam int S = 3;

  logic         CLK;
  logic         nRST;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;

  int checks = 0;
  int passed = 0;
  int fails  = 0;
  logic [W:0] exp_q[$];

  fpu_mant_addsub_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: {cout,result} is the W+1 bit value of A+B, or of A-B+2^W for subtract.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    longint unsigned xa, ya, r;
    xa = longint'(x);
    ya = longint'(y);
    r  = s ? (xa + (64'd1 << W) - ya) : (xa + ya);
    return (W + 1)'(r);
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    in_valid = v;
    a        = x;
    b        = y;
    sub      = s;
  endtask

  // One beat with out_ready high: result must show up exactly S cycles after acceptance.
  task automatic single_beat(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic s, input logic [W-1:0] er, input logic ec);
    apply_stimulus(1'b1, x, y, s);
    #1;
    check_output($sformatf("%s.in_ready", tag), in_ready, 1'b1);
    for (int i = 1; i <= S; i++) begin
      next_cycle();
      if (i == 1) apply_stimulus(1'b0, '0, '0, 1'b0);
      check_output($sformatf("%s.valid%0d", tag, i), out_valid, i == S);
    end
    check_output($sformatf("%s.result", tag), result, er);
    check_output($sformatf("%s.cout", tag), cout, ec);
    next_cycle();
    check_output($sformatf("%s.drained", tag), out_valid, 1'b0);
  endtask

  initial begin
    int   idx;
    logic acc;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    nRST      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0);
    #12;
    check_output("reset.out_valid", out_valid, 1'b0);
    check_output("reset.result", result, '0);
    check_output("reset.cout", cout, 1'b0);
    @(posedge CLK);
    #3 nRST = 1'b1;
    next_cycle();
    check_output("reset.in_ready", in_ready, 1'b1);

    single_beat("carry_ripple", 27'h7FFFFFF, 27'h0000001, 1'b0, 27'h0000000, 1'b1);
    single_beat("sub_borrow", 27'd5, 27'd7, 1'b1, 27'h7FFFFFE, 1'b0);
    single_beat("sub_pos", 27'd7, 27'd5, 1'b1, 27'h0000002, 1'b1);
    single_beat("sub_equal", 27'h4000000, 27'h4000000, 1'b1, 27'h0000000, 1'b1);
    single_beat("add_msb", 27'h4000000, 27'h4000000, 1'b0, 27'h0000000, 1'b1);
    single_beat("add_mixed", 27'h1234567, 27'h0FEDCBA, 1'b0, 27'h2222221, 1'b0);

    // Backpressure: five beats offered, three fit while stalled, all five drain in order.
    idx = 1;
    for (int cyc = 0; cyc < 11; cyc++) begin
      out_ready = (cyc >= 5);
      apply_stimulus(idx <= 5, W'(idx), W'(idx), 1'b0);
      #1;
      if (cyc < 5) check_output($sformatf("bp.in_ready%0d", cyc), in_ready, cyc < 3);
      if (cyc >= 3 && cyc <= 9) begin
        check_output($sformatf("bp.valid%0d", cyc), out_valid, 1'b1);
        check_output($sformatf("bp.result%0d", cyc), result, (cyc < 5) ? W'(2) : W'(2 * (cyc - 4)));
      end
      if (cyc == 10) check_output("bp.empty", out_valid, 1'b0);
      acc = in_valid && in_ready;
      next_cycle();
      if (acc) idx++;
    end
    check_output("bp.accepted", idx, 6);
    apply_stimulus(1'b0, '0, '0, 1'b0);

    // Flush with a full, stalled pipe plus an incoming beat that must be discarded.
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      apply_stimulus(1'b1, W'(10 + cyc), W'(1), 1'b0);
      #1;
      check_output($sformatf("fl.fill%0d", cyc), in_ready, 1'b1);
      next_cycle();
    end
    apply_stimulus(1'b1, W'(99), W'(1), 1'b0);
    flush = 1'b1;
    #1;
    check_output("fl.in_ready_pre", in_ready, 1'b0);
    check_output("fl.valid_pre", out_valid, 1'b1);
    next_cycle();
    flush     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0);
    check_output("fl.in_ready_post", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("fl.valid_post%0d", i), out_valid, 1'b0);
      next_cycle();
    end
    single_beat("post_flush", W'(100), W'(23), 1'b0, W'(123), 1'b0);

    // Asynchronous reset with two beats in flight, asserted off the clock edge.
    out_ready = 1'b0;
    apply_stimulus(1'b1, 27'h155, 27'h2AA, 1'b0);
    next_cycle();
    apply_stimulus(1'b1, 27'h3, 27'h4, 1'b1);
    next_cycle();
    apply_stimulus(1'b0, '0, '0, 1'b0);
    next_cycle();
    check_output("rst.valid_pre", out_valid, 1'b1);
    check_output("rst.result_pre", result, 27'h3FF);
    #2 nRST = 1'b0;
    #1;
    check_output("rst.valid", out_valid, 1'b0);
    check_output("rst.result", result, '0);
    check_output("rst.cout", cout, 1'b0);
    next_cycle();
    next_cycle();
    #5 nRST = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      check_output($sformatf("rst.no_stale%0d", i), out_valid, 1'b0);
    end
    single_beat("post_reset", 27'h5555555, 27'h2AAAAAA, 1'b0, 27'h7FFFFFF, 1'b0);
    single_beat("post_reset_sub", 27'h0, 27'h1, 1'b1, 27'h7FFFFFF, 1'b0);

    // Randomized traffic with handshake toggling and occasional flushes.
    exp_q.delete();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      case ($urandom_range(0, 7))
        0:       ra = '0;
        1:       ra = '1;
        default: ra = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = '1;
        default: rb = W'($urandom);
      endcase
      apply_stimulus($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      #1;
      check_output("rnd.in_ready", in_ready, out_ready || (exp_q.size() < S));
      if (exp_q.size() == 0) check_output("rnd.idle_valid", out_valid, 1'b0);
      if (out_valid && out_ready && exp_q.size() != 0)
        check_output("rnd.data", {cout, result}, exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
      next_cycle();
    end

    flush     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      if (out_valid) check_output("drain.data", {cout, result}, exp_q.pop_front());
      next_cycle();
    end
    check_output("drain.empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
